// File: rtl/genius_unidade_controle_pkg.sv
// Shared definitions for the Genius game control unit. The state codes are
// also used by the datapath's 7-segment debug decoder.
package genius_unidade_controle_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL         = 4'h0,
    ST_PREPARACAO      = 4'h1,
    ST_INICIO_RODADA   = 4'h2,
    ST_MOSTRA_LED      = 4'h3,
    ST_APAGA_LED       = 4'h4,
    ST_PROXIMO_LED     = 4'h5,
    ST_ESPERA_JOGADA   = 4'h6,
    ST_REGISTRA        = 4'h7,
    ST_MOSTRA_JOGADA   = 4'h8,
    ST_COMPARA         = 4'h9,
    ST_PROXIMA_JOGADA  = 4'hA,
    ST_PROXIMA_RODADA  = 4'hB,
    ST_FIM_ACERTOU     = 4'hC,
    ST_FIM_ERROU       = 4'hD,
    ST_FIM_TIMEOUT     = 4'hE,
    ST_INICIA_JOGADAS  = 4'hF
  } estado_t;

  // Last round depends on game length: index 7 for 8 rounds, 15 for 16 rounds.
  function automatic logic ultima_rodada(input logic nivel_jogadas,
                                         input logic fim_cr,
                                         input logic meio_cr);
    return nivel_jogadas ? fim_cr : meio_cr;
  endfunction

endpackage

// File: rtl/genius_unidade_controle_if.sv
// Control/condition bundle between the Genius control unit and its datapath.
interface genius_unidade_controle_if;

  logic       iniciar, jogada_feita, jogada_correta, enderecoIgualRodada;
  logic       nivel_jogadas_reg, nivel_tempo_reg;
  logic       fimCR, meioCR, fimTM, meioTM, fimTempo;
  logic       zeraR, registraR, zeraC, contaC, registraN, zeraCR, contaCR;
  logic       zeraTM, contaTM, zeraTempo, contaTempo;
  logic       ativa_leds_mem, ativa_leds_jog, toca;
  logic       pronto, ganhou, perdeu, timeout;
  logic [3:0] db_estado;

  // Control unit side: consumes conditions, drives strobes and status.
  modport master (
    input  iniciar, jogada_feita, jogada_correta, enderecoIgualRodada,
           nivel_jogadas_reg, nivel_tempo_reg, fimCR, meioCR, fimTM, meioTM,
           fimTempo,
    output zeraR, registraR, zeraC, contaC, registraN, zeraCR, contaCR,
           zeraTM, contaTM, zeraTempo, contaTempo, ativa_leds_mem,
           ativa_leds_jog, toca, pronto, ganhou, perdeu, timeout, db_estado
  );

  modport slave (
    output iniciar, jogada_feita, jogada_correta, enderecoIgualRodada,
           nivel_jogadas_reg, nivel_tempo_reg, fimCR, meioCR, fimTM, meioTM,
           fimTempo,
    input  zeraR, registraR, zeraC, contaC, registraN, zeraCR, contaCR,
           zeraTM, contaTM, zeraTempo, contaTempo, ativa_leds_mem,
           ativa_leds_jog, toca, pronto, ganhou, perdeu, timeout, db_estado
  );

endinterface

// File: rtl/genius_unidade_controle.sv
// Moore FSM sequencing the Genius game: show sequence, collect moves, and
// finish with win, error or timeout. Outputs decode the state only.
module genius_unidade_controle
  import genius_unidade_controle_pkg::*;
(
  input logic                        clock,
  input logic                        reset,
  genius_unidade_controle_if.master  uc
);

  estado_t state_q, state_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_INICIAL;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so that any path that does
  // not assign it holds the state instead of inferring a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INICIAL:        if (uc.iniciar) state_d = ST_PREPARACAO;
      ST_PREPARACAO:     state_d = ST_INICIO_RODADA;
      ST_INICIO_RODADA:  state_d = ST_MOSTRA_LED;
      ST_MOSTRA_LED:     if (uc.meioTM) state_d = ST_APAGA_LED;
      ST_APAGA_LED: begin
        if (uc.fimTM && uc.enderecoIgualRodada) state_d = ST_INICIA_JOGADAS;
        else if (uc.fimTM)                      state_d = ST_PROXIMO_LED;
      end
      ST_PROXIMO_LED:    state_d = ST_MOSTRA_LED;
      ST_INICIA_JOGADAS: state_d = ST_ESPERA_JOGADA;
      ST_ESPERA_JOGADA: begin
        // A move in the same cycle as the timer expiring still counts.
        if (uc.jogada_feita)                          state_d = ST_REGISTRA;
        else if (uc.fimTempo && uc.nivel_tempo_reg)   state_d = ST_FIM_TIMEOUT;
      end
      ST_REGISTRA:       state_d = ST_MOSTRA_JOGADA;
      ST_MOSTRA_JOGADA:  if (uc.meioTM) state_d = ST_COMPARA;
      ST_COMPARA: begin
        if (!uc.jogada_correta)
          state_d = ST_FIM_ERROU;
        else if (uc.enderecoIgualRodada &&
                 ultima_rodada(uc.nivel_jogadas_reg, uc.fimCR, uc.meioCR))
          state_d = ST_FIM_ACERTOU;
        else if (uc.enderecoIgualRodada)
          state_d = ST_PROXIMA_RODADA;
        else
          state_d = ST_PROXIMA_JOGADA;
      end
      ST_PROXIMA_JOGADA: state_d = ST_ESPERA_JOGADA;
      ST_PROXIMA_RODADA: state_d = ST_INICIO_RODADA;
      ST_FIM_ACERTOU,
      ST_FIM_ERROU,
      ST_FIM_TIMEOUT:    if (uc.iniciar) state_d = ST_PREPARACAO;
      default:           state_d = ST_INICIAL;
    endcase
  end

  always_comb begin
    uc.zeraR          = 1'b0;
    uc.registraR      = 1'b0;
    uc.zeraC          = 1'b0;
    uc.contaC         = 1'b0;
    uc.registraN      = 1'b0;
    uc.zeraCR         = 1'b0;
    uc.contaCR        = 1'b0;
    uc.zeraTM         = 1'b0;
    uc.contaTM        = 1'b0;
    uc.zeraTempo      = 1'b0;
    uc.contaTempo     = 1'b0;
    uc.ativa_leds_mem = 1'b0;
    uc.ativa_leds_jog = 1'b0;
    uc.toca           = 1'b0;
    uc.pronto         = 1'b0;
    uc.ganhou         = 1'b0;
    uc.perdeu         = 1'b0;
    uc.timeout        = 1'b0;
    unique case (state_q)
      ST_INICIAL:        uc.zeraR = 1'b1;
      ST_PREPARACAO: begin
        uc.registraN = 1'b1;
        uc.zeraCR    = 1'b1;
        uc.zeraC     = 1'b1;
        uc.zeraTM    = 1'b1;
      end
      ST_INICIO_RODADA: begin
        uc.zeraC  = 1'b1;
        uc.zeraTM = 1'b1;
      end
      ST_MOSTRA_LED: begin
        uc.ativa_leds_mem = 1'b1;
        uc.toca           = 1'b1;
        uc.contaTM        = 1'b1;
      end
      ST_APAGA_LED:      uc.contaTM = 1'b1;
      ST_PROXIMO_LED: begin
        uc.contaC = 1'b1;
        uc.zeraTM = 1'b1;
      end
      ST_INICIA_JOGADAS: begin
        uc.zeraC     = 1'b1;
        uc.zeraTempo = 1'b1;
      end
      ST_ESPERA_JOGADA:  uc.contaTempo = 1'b1;
      ST_REGISTRA: begin
        uc.registraR = 1'b1;
        uc.zeraTM    = 1'b1;
      end
      ST_MOSTRA_JOGADA: begin
        uc.ativa_leds_jog = 1'b1;
        uc.toca           = 1'b1;
        uc.contaTM        = 1'b1;
      end
      ST_PROXIMA_JOGADA: begin
        uc.contaC    = 1'b1;
        uc.zeraTempo = 1'b1;
      end
      ST_PROXIMA_RODADA: uc.contaCR = 1'b1;
      ST_FIM_ACERTOU: begin
        uc.zeraR  = 1'b1;
        uc.pronto = 1'b1;
        uc.ganhou = 1'b1;
      end
      ST_FIM_ERROU: begin
        uc.zeraR  = 1'b1;
        uc.pronto = 1'b1;
        uc.perdeu = 1'b1;
      end
      ST_FIM_TIMEOUT: begin
        uc.zeraR   = 1'b1;
        uc.pronto  = 1'b1;
        uc.perdeu  = 1'b1;
        uc.timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign uc.db_estado = state_q;

endmodule

// File: tb/tb_genius_unidade_controle.sv
// Directed bench for the Genius control unit: walks the game flow and checks
// state codes and the full output decode against hand-written expectations.
module tb_genius_unidade_controle;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total  = 0;
  int   passed = 0;

  genius_unidade_controle_if dif ();

  genius_unidade_controle dut (
    .clock (clock),
    .reset (reset),
    .uc    (dif.master)
  );

  always #5 clock = ~clock;

  // {zeraR, registraR, zeraC, contaC, registraN, zeraCR, contaCR, zeraTM,
  //  contaTM, zeraTempo, contaTempo, leds_mem, leds_jog, toca,
  //  pronto, ganhou, perdeu, timeout}
  logic [17:0] outs;
  assign outs = {dif.zeraR, dif.registraR, dif.zeraC, dif.contaC, dif.registraN,
                 dif.zeraCR, dif.contaCR, dif.zeraTM, dif.contaTM, dif.zeraTempo,
                 dif.contaTempo, dif.ativa_leds_mem, dif.ativa_leds_jog, dif.toca,
                 dif.pronto, dif.ganhou, dif.perdeu, dif.timeout};

  function automatic logic [17:0] exp_outs(input logic [3:0] s);
    case (s)
      4'h0: return 18'b100000000000000000;
      4'h1: return 18'b001011010000000000;
      4'h2: return 18'b001000010000000000;
      4'h3: return 18'b000000001001010000;
      4'h4: return 18'b000000001000000000;
      4'h5: return 18'b000100010000000000;
      4'h6: return 18'b000000000010000000;
      4'h7: return 18'b010000010000000000;
      4'h8: return 18'b000000001000110000;
      4'h9: return 18'b000000000000000000;
      4'hA: return 18'b000100000100000000;
      4'hB: return 18'b000000100000000000;
      4'hC: return 18'b100000000000001100;
      4'hD: return 18'b100000000000001010;
      4'hE: return 18'b100000000000001011;
      4'hF: return 18'b001000000100000000;
      default: return 18'b0;
    endcase
  endfunction

  task automatic clear_inputs();
    dif.iniciar = 0; dif.jogada_feita = 0; dif.jogada_correta = 0;
    dif.enderecoIgualRodada = 0; dif.nivel_jogadas_reg = 0;
    dif.nivel_tempo_reg = 0; dif.fimCR = 0; dif.meioCR = 0;
    dif.fimTM = 0; dif.meioTM = 0; dif.fimTempo = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b0;
    #2;
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Reset, then drive a one-round display sequence to land in state 6.
  task automatic goto_espera();
    apply_reset();
    dif.iniciar = 1; step(); dif.iniciar = 0;
    step(); step();
    dif.meioTM = 1; step(); dif.meioTM = 0;
    dif.fimTM = 1; dif.enderecoIgualRodada = 1; step();
    dif.fimTM = 0; dif.enderecoIgualRodada = 0; step();
  endtask

  task automatic goto_mostra_jogada();
    goto_espera();
    dif.jogada_feita = 1; step(); dif.jogada_feita = 0;
    step();
  endtask

  task automatic goto_compara();
    goto_mostra_jogada();
    dif.meioTM = 1; step(); dif.meioTM = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    #3;
    total++; if (dif.db_estado !== 4'h0 || outs !== exp_outs(4'h0))
      $display("FAIL reset_hold: estado=%h outs=%b required estado=0 outs=%b", dif.db_estado, outs, exp_outs(4'h0));
    else passed++;
    @(negedge clock); reset = 1'b1;
    step(); step();
    total++; if (dif.db_estado !== 4'h0 || outs !== exp_outs(4'h0))
      $display("FAIL idle_no_start: estado=%h outs=%b required estado=0 outs=%b", dif.db_estado, outs, exp_outs(4'h0));
    else passed++;
  endtask

  task automatic test_start();
    dif.iniciar = 1; step(); dif.iniciar = 0;
    total++; if (dif.db_estado !== 4'h1 || outs !== exp_outs(4'h1))
      $display("FAIL start_preparacao: estado=%h outs=%b required estado=1 outs=%b", dif.db_estado, outs, exp_outs(4'h1));
    else passed++;
    step();
    total++; if (dif.db_estado !== 4'h2 || outs !== exp_outs(4'h2))
      $display("FAIL start_inicio_rodada: estado=%h outs=%b required estado=2 outs=%b", dif.db_estado, outs, exp_outs(4'h2));
    else passed++;
  endtask

  // Continues from state 2 left by test_start: full round 0 with one move.
  task automatic test_round0();
    logic [3:0] exp_seq [8];
    exp_seq = '{4'h3, 4'h4, 4'hF, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB};
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      case (i)
        1: dif.meioTM = 1;
        2: begin dif.fimTM = 1; dif.enderecoIgualRodada = 1; end
        4: dif.jogada_feita = 1;
        6: dif.meioTM = 1;
        7: begin dif.jogada_correta = 1; dif.enderecoIgualRodada = 1; end
        default: ;
      endcase
      step();
      total++; if (dif.db_estado !== exp_seq[i] || outs !== exp_outs(exp_seq[i]))
        $display("FAIL round0_step%0d: estado=%h outs=%b required estado=%h outs=%b", i, dif.db_estado, outs, exp_seq[i], exp_outs(exp_seq[i]));
      else passed++;
    end
    clear_inputs(); step();
    total++; if (dif.db_estado !== 4'h2)
      $display("FAIL round0_next_round: estado=%h required 2", dif.db_estado);
    else passed++;
  endtask

  // Display of two words (4 -> 5 -> 3) and a non-final correct move (9 -> A -> 6).
  task automatic test_multi_word();
    step();
    dif.meioTM = 1; step(); dif.meioTM = 0;
    dif.fimTM = 1; step(); dif.fimTM = 0;
    total++; if (dif.db_estado !== 4'h5 || outs !== exp_outs(4'h5))
      $display("FAIL proximo_led: estado=%h outs=%b required estado=5 outs=%b", dif.db_estado, outs, exp_outs(4'h5));
    else passed++;
    step();
    total++; if (dif.db_estado !== 4'h3)
      $display("FAIL back_to_mostra: estado=%h required 3", dif.db_estado);
    else passed++;
    dif.meioTM = 1; step(); dif.meioTM = 0;
    dif.fimTM = 1; dif.enderecoIgualRodada = 1; step(); clear_inputs();
    step();
    dif.jogada_feita = 1; step(); dif.jogada_feita = 0;
    step();
    dif.meioTM = 1; step(); dif.meioTM = 0;
    dif.jogada_correta = 1; step(); dif.jogada_correta = 0;
    total++; if (dif.db_estado !== 4'hA || outs !== exp_outs(4'hA))
      $display("FAIL proxima_jogada: estado=%h outs=%b required estado=A outs=%b", dif.db_estado, outs, exp_outs(4'hA));
    else passed++;
    step();
    total++; if (dif.db_estado !== 4'h6)
      $display("FAIL back_to_espera: estado=%h required 6", dif.db_estado);
    else passed++;
  endtask

  task automatic test_final_round();
    goto_compara();
    dif.jogada_correta = 1; dif.enderecoIgualRodada = 1; dif.meioCR = 1;
    step(); clear_inputs();
    total++; if (dif.db_estado !== 4'hC || outs !== exp_outs(4'hC))
      $display("FAIL win_8_rounds: estado=%h outs=%b required estado=C outs=%b", dif.db_estado, outs, exp_outs(4'hC));
    else passed++;
    step(); step();
    total++; if (dif.db_estado !== 4'hC)
      $display("FAIL win_holds: estado=%h required C", dif.db_estado);
    else passed++;
    goto_compara();
    dif.nivel_jogadas_reg = 1; dif.jogada_correta = 1;
    dif.enderecoIgualRodada = 1; dif.meioCR = 1; dif.fimCR = 0;
    step(); clear_inputs();
    total++; if (dif.db_estado !== 4'hB)
      $display("FAIL long_game_round7: estado=%h required B", dif.db_estado);
    else passed++;
    goto_compara();
    dif.nivel_jogadas_reg = 1; dif.jogada_correta = 1;
    dif.enderecoIgualRodada = 1; dif.fimCR = 1;
    step(); clear_inputs();
    total++; if (dif.db_estado !== 4'hC)
      $display("FAIL win_16_rounds: estado=%h required C", dif.db_estado);
    else passed++;
  endtask

  task automatic test_error();
    goto_compara();
    dif.jogada_correta = 0; dif.enderecoIgualRodada = 1; dif.meioCR = 1;
    step(); clear_inputs();
    total++; if (dif.db_estado !== 4'hD || outs !== exp_outs(4'hD))
      $display("FAIL wrong_move: estado=%h outs=%b required estado=D outs=%b", dif.db_estado, outs, exp_outs(4'hD));
    else passed++;
    dif.iniciar = 1; step();
    total++; if (dif.db_estado !== 4'h1)
      $display("FAIL restart_from_error: estado=%h required 1", dif.db_estado);
    else passed++;
    dif.iniciar = 0;
  endtask

  task automatic test_timeout();
    int stray;
    goto_espera();
    dif.nivel_tempo_reg = 1; dif.fimTempo = 1; step(); clear_inputs();
    total++; if (dif.db_estado !== 4'hE || outs !== exp_outs(4'hE))
      $display("FAIL timeout: estado=%h outs=%b required estado=E outs=%b", dif.db_estado, outs, exp_outs(4'hE));
    else passed++;
    dif.iniciar = 1; step(); dif.iniciar = 0;
    total++; if (dif.db_estado !== 4'h1)
      $display("FAIL restart_from_timeout: estado=%h required 1", dif.db_estado);
    else passed++;
    goto_espera();
    dif.nivel_tempo_reg = 1; dif.fimTempo = 1; dif.jogada_feita = 1;
    step(); clear_inputs();
    total++; if (dif.db_estado !== 4'h7)
      $display("FAIL move_beats_timeout: estado=%h required 7", dif.db_estado);
    else passed++;
    goto_espera();
    dif.nivel_tempo_reg = 0; dif.fimTempo = 1; dif.iniciar = 1;
    stray = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (dif.db_estado !== 4'h6) stray++;
    end
    clear_inputs();
    total++; if (stray !== 0)
      $display("FAIL timeout_disabled: cycles_out_of_6=%0d required 0", stray);
    else passed++;
  endtask

  task automatic test_async_reset();
    goto_mostra_jogada();
    total++; if (dif.db_estado !== 4'h8 || dif.ativa_leds_jog !== 1'b1 || dif.toca !== 1'b1)
      $display("FAIL pre_reset_state8: estado=%h leds_jog=%b toca=%b required 8 1 1", dif.db_estado, dif.ativa_leds_jog, dif.toca);
    else passed++;
    dif.fimTM = 1; dif.meioTM = 0;
    reset = 1'b0;
    #1;
    total++; if (dif.db_estado !== 4'h0 || dif.ativa_leds_jog !== 1'b0 || dif.toca !== 1'b0)
      $display("FAIL async_reset: estado=%h leds_jog=%b toca=%b required 0 0 0", dif.db_estado, dif.ativa_leds_jog, dif.toca);
    else passed++;
    clear_inputs();
    @(negedge clock); reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start();
    test_round0();
    test_multi_word();
    test_final_round();
    test_error();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
